// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 encodings and the misalignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] WEB_NONE = 4'hF;

    // Halfwords must sit on an even byte, words on a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bundle of the load/store unit. The core is the
// master; the LSU is the slave.
interface lsu_mem_ctrl_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        stall_o;

    modport master (
        output req_valid_i,
        output req_we_i,
        output req_funct3_i,
        output req_addr_i,
        output req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_rdata_o,
        input  rsp_err_o,
        input  stall_o
    );

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  req_funct3_i,
        input  req_addr_i,
        input  req_wdata_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_rdata_o,
        output rsp_err_o,
        output stall_o
    );

endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Combinational byte-lane steering: store data replication / write enables
// and load byte/half extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_web,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [3:0]  byte_sel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_sel[gi] = (st_offset == 2'(gi));
        end
    endgenerate

    always_comb begin
        st_data = st_wdata;
        st_web  = 4'b0000;
        case (st_funct3)
            F3_B: begin
                st_data = {4{st_wdata[7:0]}};
                st_web  = ~byte_sel;
            end
            F3_H: begin
                st_data = {2{st_wdata[15:0]}};
                st_web  = st_offset[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                st_data = st_wdata;
                st_web  = 4'b0000;
            end
        endcase
    end

    assign ld_byte = ld_word[8*ld_offset +: 8];
    assign ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between an RV32I core and a fixed-latency data SRAM.
// Optional misalignment trapping is enabled with LSU_MISALIGN_CHK_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    lsu_mem_ctrl_if.slave         core,
    output logic                  mem_oe_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [3:0]            mem_web_o,
    output logic [31:0]           mem_di_o,
    input  logic [31:0]           mem_do_i
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_latency
            $error("lsu_mem_ctrl: MEM_LATENCY must be in 1..8");
        end
    endgenerate

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    lsu_state_t            state_reg;
    logic                  we_reg;
    logic [2:0]            funct3_reg;
    logic [1:0]            offset_reg;
    logic                  err_reg;
    logic [3:0]            cnt_reg;
    logic                  mem_oe_reg;
    logic [ADDR_WIDTH-1:0] mem_a_reg;
    logic [3:0]            mem_web_reg;
    logic [31:0]           mem_di_reg;
    logic                  rsp_valid_reg;
    logic [31:0]           rsp_rdata_reg;
    logic                  rsp_err_reg;

    logic                  mis_req;
    logic [31:0]           st_data;
    logic [3:0]            st_web;
    logic [31:0]           ld_data;
    logic                  unused_addr;

    assign unused_addr = ^core.req_addr_i[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_CHK_EN
    assign mis_req = is_misaligned(core.req_funct3_i, core.req_addr_i[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    // Store side works on the live request; load side on the captured one.
    lsu_lane_align u_align (
        .st_funct3 (core.req_funct3_i),
        .st_offset (core.req_addr_i[1:0]),
        .st_wdata  (core.req_wdata_i),
        .st_data   (st_data),
        .st_web    (st_web),
        .ld_funct3 (funct3_reg),
        .ld_offset (offset_reg),
        .ld_word   (mem_do_i),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'd0;
            offset_reg    <= 2'd0;
            err_reg       <= 1'b0;
            cnt_reg       <= 4'd0;
            mem_oe_reg    <= 1'b0;
            mem_a_reg     <= '0;
            mem_web_reg   <= WEB_NONE;
            mem_di_reg    <= 32'd0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    if (core.req_valid_i) begin
                        we_reg     <= core.req_we_i;
                        funct3_reg <= core.req_funct3_i;
                        offset_reg <= core.req_addr_i[1:0];
                        err_reg    <= mis_req;
                        mem_a_reg  <= core.req_addr_i[ADDR_WIDTH+1:2];
                        mem_oe_reg <= !core.req_we_i && !mis_req;
                        if (core.req_we_i && !mis_req) begin
                            mem_di_reg  <= st_data;
                            mem_web_reg <= st_web;
                        end
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Stores and trapped accesses finish without waiting on read data.
                    if (we_reg || err_reg) begin
                        mem_web_reg   <= WEB_NONE;
                        mem_oe_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= err_reg;
                        rsp_rdata_reg <= 32'd0;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg   <= 4'd1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == LAT) begin
                        rsp_rdata_reg <= ld_data;
                        mem_oe_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign core.req_ready_o = (state_reg == IDLE);
    assign core.stall_o     = rst_i && ((state_reg == IDLE) ? core.req_valid_i
                                        : (state_reg == ACCESS || state_reg == WAIT));
    assign core.rsp_valid_o = rsp_valid_reg;
    assign core.rsp_rdata_o = rsp_rdata_reg;
    assign core.rsp_err_o   = rsp_err_reg;

    assign mem_oe_o  = mem_oe_reg;
    assign mem_a_o   = mem_a_reg;
    assign mem_web_o = mem_web_reg;
    assign mem_di_o  = mem_di_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised bench for lsu_mem_ctrl against a byte-addressed reference memory.
// Honours LSU_MISALIGN_CHK_EN when computing expected responses.
module tb_lsu_mem_ctrl;

    localparam int AW  = 6;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_oe;
    logic [AW-1:0] mem_a;
    logic [3:0]    mem_web;
    logic [31:0]   mem_di;
    logic [31:0]   mem_do;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .core      (bus.slave),
        .mem_oe_o  (mem_oe),
        .mem_a_o   (mem_a),
        .mem_web_o (mem_web),
        .mem_di_o  (mem_di),
        .mem_do_i  (mem_do)
    );

    // SRAM device: byte-write array, read data valid LAT cycles after the address cycle
    logic [31:0] sram [2**AW];
    logic [31:0] pipe [LAT];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (!mem_web[b]) sram[mem_a][8*b +: 8] <= mem_di[8*b +: 8];
        pipe[0] <= mem_oe ? sram[mem_a] : $urandom;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_do = pipe[LAT-1];

    // Reference model: plain byte memory, little endian
    logic [7:0] ref_mem [256];

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_mem[b+8'd3], ref_mem[b+8'd2], ref_mem[b+8'd1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [7:0] a);
        logic [7:0]  bt;
        logic [15:0] hw;
        bt = ref_mem[a];
        hw = {ref_mem[{a[7:1], 1'b1}], ref_mem[{a[7:1], 1'b0}]};
        case (f3)
            3'd0:    return 32'($signed(bt));
            3'd1:    return 32'($signed(hw));
            3'd4:    return {24'd0, bt};
            3'd5:    return {16'd0, hw};
            default: return ref_word(a);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [7:0] a);
        case (f3)
            3'd0:    return 4'b0001 << a[1:0];
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        case (f3)
            3'd0: ref_mem[a] = wd[7:0];
            3'd1: begin
                ref_mem[{a[7:1], 1'b0}] = wd[7:0];
                ref_mem[{a[7:1], 1'b1}] = wd[15:8];
            end
            default: for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'(i)}] = wd[8*i +: 8];
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request now and follows it to one cycle past its response.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
        logic        mis;
        logic [7:0]  a;
        logic [3:0]  exp_web;
        logic        exp_oe;
        logic [31:0] exp_di, exp_rd;
        int          exp_lat, cyc;
        a   = addr[7:0];
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
`endif
        exp_web = (we && !mis) ? ~lane_mask(f3, a) : 4'hF;
        exp_oe  = !we && !mis;
        exp_di  = (f3 == 3'd0) ? {4{wdata[7:0]}} : (f3 == 3'd1) ? {2{wdata[15:0]}} : wdata;
        exp_rd  = (we || mis) ? 32'd0 : ref_load(f3, a);
        exp_lat = (we || mis) ? 2 : 2 + LAT;
        if (we && !mis) ref_store(f3, a, wdata);

        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        #1;
        chk("t0_ready", 32'(bus.req_ready_o), 32'd1);
        chk("t0_stall", 32'(bus.stall_o), 32'd1);
        @(posedge clk); #1;
        cyc = 1;
        chk("acc_oe", 32'(mem_oe), 32'(exp_oe));
        chk("acc_web", 32'(mem_web), 32'(exp_web));
        if (!mis) chk("acc_addr", 32'(mem_a), 32'(addr[AW+1:2]));
        if (we && !mis) chk("acc_di", mem_di, exp_di);
        while (!bus.rsp_valid_o && cyc < 20) begin
            chk("busy_stall", 32'(bus.stall_o), 32'd1);
            if (cyc >= 2) begin
                chk("wait_oe", 32'(mem_oe), 32'd1);
                chk("wait_addr", 32'(mem_a), 32'(addr[AW+1:2]));
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("rsp_latency", 32'(cyc), 32'(exp_lat));
        chk("rsp_rdata", bus.rsp_rdata_o, exp_rd);
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(mis));
        chk("rsp_stall", 32'(bus.stall_o), 32'd0);
        chk("rsp_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rsp_web", 32'(mem_web), 32'hF);
        $display("txn we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 we, f3, addr, wdata, bus.rsp_rdata_o, bus.rsp_err_o, cyc);
        @(posedge clk); #1;
        chk("post_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("post_ready", 32'(bus.req_ready_o), 32'd1);
        chk("post_rdata_hold", bus.rsp_rdata_o, exp_rd);
    endtask

    task automatic idle(input int n);
        bus.req_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        end
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [2:0]  st_f3 [5];
        st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'd0;
        bus.req_addr_i   = 32'd0;
        bus.req_wdata_i  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_oe", 32'(mem_oe), 32'd0);
        chk("rst_web", 32'(mem_web), 32'hF);
        chk("rst_addr", 32'(mem_a), 32'd0);
        chk("rst_di", mem_di, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill memory word by word, with junk in the ignored upper address bits
        for (int w = 0; w < 2**AW; w++)
            txn(1'b1, 3'd2, {$urandom_range(0, 2**24 - 1), 6'(w), 2'b00}, $urandom);
        idle(1);

        txn(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
        txn(1'b0, 3'd2, 32'h0000_0010, 32'd0);
        idle(1);
        txn(1'b1, 3'd2, 32'h0000_0020, 32'h8081_7F82);
        txn(1'b0, 3'd0, 32'h0000_0021, 32'd0);
        txn(1'b0, 3'd0, 32'h0000_0023, 32'd0);
        txn(1'b0, 3'd4, 32'h0000_0023, 32'd0);
        idle(2);
        txn(1'b1, 3'd1, 32'h0000_0006, 32'h0000_A5C3);
        txn(1'b0, 3'd1, 32'h0000_0006, 32'd0);
        txn(1'b0, 3'd5, 32'h0000_0006, 32'd0);
        idle(1);
        txn(1'b0, 3'd2, 32'h0000_0012, 32'd0);
        txn(1'b1, 3'd2, 32'h0000_0032, 32'h1234_5678);
        txn(1'b0, 3'd2, 32'h0000_0030, 32'd0);

        // Reset while a load sits in WAIT
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'd2;
        bus.req_addr_i   = 32'h0000_0040;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_oe", 32'(mem_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", 32'(mem_oe), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall_o), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("mid_rst_addr", 32'(mem_a), 32'd0);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(LAT + 3);
        txn(1'b0, 3'd2, 32'h0000_0040, 32'd0);

        // Random traffic, sometimes back to back
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            txn(we, f3, $urandom, $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
